s_axil_register_slave: RTL and testbench

- AXI4-Lite slave register file: the responder end of our AXI-Lite register master BFM.
- Holds NUM_REG words, byte-strobed write path, registered read path, one outstanding transaction per direction.
- Sits behind the interconnect as the DUT the master BFM drives.

---
 rtl/s_axil_register_slave.sv | 128 ++++++++++++
 tb/tb_s_axil_register_slave.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_axil_register_slave.sv
// s_axil_register_slave: AXI4-Lite register file with byte-strobed writes and registered reads.
// AW and W are captured independently; the write commits when both are held.
module s_axil_register_slave #(
    parameter int S_AXI_DATA_WIDTH = 32,
    parameter int S_AXI_ADDR_WIDTH = 32,
    parameter int NUM_REG          = 16
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [S_AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [S_AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [S_AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                          WVALID,
    output logic                          WREADY,
    output logic [1:0]                    BRESP,
    output logic                          BVALID,
    input  logic                          BREADY,
    input  logic [S_AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic                          ARVALID,
    output logic                          ARREADY,
    output logic [S_AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                    RRESP,
    output logic                          RVALID,
    input  logic                          RREADY
);
    localparam int IW = $clog2(NUM_REG);
    localparam int SW = S_AXI_DATA_WIDTH / 8;
    localparam logic [S_AXI_ADDR_WIDTH-1:0] LIMIT = S_AXI_ADDR_WIDTH'(NUM_REG * 4);

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t r_wstate, w_wstate_nx;
    r_state_t r_rstate, w_rstate_nx;
    logic [S_AXI_DATA_WIDTH-1:0] r_regs [NUM_REG];
    logic [S_AXI_ADDR_WIDTH-1:0] r_awaddr, w_awaddr;
    logic [S_AXI_DATA_WIDTH-1:0] r_wdata, w_wdata, r_rdata;
    logic [SW-1:0]               r_wstrb, w_wstrb;
    logic [1:0]                  r_bresp, r_rresp;
    logic r_aw_held, r_w_held, r_awready, r_wready, r_arready;
    logic w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_aw_held_nx, w_w_held_nx, w_wr_ok, w_rd_ok;

    assign w_aw_hs      = AWVALID & r_awready;
    assign w_w_hs       = WVALID & r_wready;
    assign w_ar_hs      = ARVALID & r_arready;
    // A channel captured on this very edge is used straight from the bus
    assign w_awaddr     = r_aw_held ? r_awaddr : AWADDR;
    assign w_wdata      = r_w_held ? r_wdata : WDATA;
    assign w_wstrb      = r_w_held ? r_wstrb : WSTRB;
    assign w_commit     = (r_wstate == W_IDLE) & (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
    assign w_aw_held_nx = ~w_commit & (r_aw_held | w_aw_hs);
    assign w_w_held_nx  = ~w_commit & (r_w_held | w_w_hs);
    assign w_wr_ok      = w_awaddr < LIMIT;
    assign w_rd_ok      = ARADDR < LIMIT;

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nx;
            r_rstate <= w_rstate_nx;
        end
    end

    always_comb begin
        w_wstate_nx = r_wstate;
        w_rstate_nx = r_rstate;
        if (w_commit)
            w_wstate_nx = W_RESP;
        else if (r_wstate == W_RESP && BREADY)
            w_wstate_nx = W_IDLE;
        if (w_ar_hs)
            w_rstate_nx = R_DATA;
        else if (r_rstate == R_DATA && RREADY)
            w_rstate_nx = R_IDLE;
    end

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            for (int i = 0; i < NUM_REG; i++) r_regs[i] <= '0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_arready <= 1'b0;
            r_bresp   <= 2'b00;
            r_rresp   <= 2'b00;
            r_rdata   <= '0;
        end else begin
            r_aw_held <= w_aw_held_nx;
            r_w_held  <= w_w_held_nx;
            r_awready <= (w_wstate_nx == W_IDLE) & ~w_aw_held_nx;
            r_wready  <= (w_wstate_nx == W_IDLE) & ~w_w_held_nx;
            r_arready <= w_rstate_nx == R_IDLE;
            if (w_aw_hs) r_awaddr <= AWADDR;
            if (w_w_hs) begin
                r_wdata <= WDATA;
                r_wstrb <= WSTRB;
            end
            if (w_commit) begin
                r_bresp <= w_wr_ok ? 2'b00 : 2'b10;
                if (w_wr_ok)
                    for (int b = 0; b < SW; b++)
                        if (w_wstrb[b]) r_regs[w_awaddr[IW+1:2]][8*b +: 8] <= w_wdata[8*b +: 8];
            end
            // Non-blocking read of r_regs yields the pre-write value on a same-edge commit
            if (w_ar_hs) begin
                r_rdata <= w_rd_ok ? r_regs[ARADDR[IW+1:2]] : '0;
                r_rresp <= w_rd_ok ? 2'b00 : 2'b10;
            end
        end
    end

    assign AWREADY = r_awready;
    assign WREADY  = r_wready;
    assign BVALID  = r_wstate == W_RESP;
    assign BRESP   = r_bresp;
    assign ARREADY = r_arready;
    assign RVALID  = r_rstate == R_DATA;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;
endmodule

// File: tb/tb_s_axil_register_slave.sv
// tb_s_axil_register_slave: randomized AXI-Lite master driving the register slave,
// checked against an array-of-words reference model.
module tb_s_axil_register_slave;
    logic        ACLK = 0, ARESET = 0;
    logic [31:0] AWADDR = 0, WDATA = 0, ARADDR = 0, RDATA;
    logic [3:0]  WSTRB = 0;
    logic        AWVALID = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]  BRESP, RRESP;

    int n_tests = 0, n_fail = 0;
    logic [31:0] model [16];

    s_axil_register_slave dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        if (a >= 32'd64) return;
        idx = int'(a) / 4;
        for (int b = 0; b < 4; b++)
            if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
    endfunction

    // viol counts protocol breaches seen during the transaction; dlat = BREADY-handshake cycle minus both-captured cycle
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int awd, input int wd, input int bd,
                            output logic [1:0] resp, output int dlat, output int viol);
        bit aw_done = 0, w_done = 0, b_done = 0, aw_hs, w_hs, b_hs;
        int cyc = 0, t_both = -1, t_b = -1;
        logic [1:0] r0 = 2'b00;
        viol = 0; dlat = -1; resp = 2'b11;
        while (!b_done && cyc < 300) begin
            @(negedge ACLK);
            AWADDR = a; WDATA = d; WSTRB = s;
            AWVALID = !aw_done && cyc >= awd;
            WVALID  = !w_done && cyc >= wd;
            BREADY  = cyc >= bd;
            if (aw_done && AWREADY) viol++;
            if (w_done && WREADY) viol++;
            if (BVALID && !(aw_done && w_done)) viol++;
            if (BVALID) begin
                if (t_b < 0) begin
                    t_b = cyc; r0 = BRESP;
                    if (t_b != t_both + 1) viol++;
                end else if (BRESP !== r0) viol++;
            end
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            b_hs  = BVALID && BREADY;
            @(posedge ACLK);
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            if (aw_done && w_done && t_both < 0) t_both = cyc;
            if (b_hs) begin b_done = 1; resp = r0; dlat = cyc - t_both; end
            cyc++;
        end
        #1;
        AWVALID = 0; WVALID = 0; BREADY = 0;
        if (!b_done) begin
            n_tests++; n_fail++;
            $display("FAIL write_timeout addr=%h got no B handshake, required one within 300 cycles", a);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input int ard, input int rd,
                           output logic [31:0] data, output logic [1:0] resp, output int dlat, output int viol);
        bit ar_done = 0, r_done = 0, ar_hs, r_hs;
        int cyc = 0, t_ar = -1, t_r = -1;
        logic [31:0] d0 = 0;
        logic [1:0] r0 = 0;
        viol = 0; dlat = -1; data = 32'hxxxx_xxxx; resp = 2'b11;
        while (!r_done && cyc < 300) begin
            @(negedge ACLK);
            ARADDR = a;
            ARVALID = !ar_done && cyc >= ard;
            RREADY  = cyc >= rd;
            if (ar_done && ARREADY) viol++;
            if (RVALID && !ar_done) viol++;
            if (RVALID) begin
                if (t_r < 0) begin
                    t_r = cyc; d0 = RDATA; r0 = RRESP;
                    if (t_r != t_ar + 1) viol++;
                end else if (RDATA !== d0 || RRESP !== r0) viol++;
            end
            ar_hs = ARVALID && ARREADY;
            r_hs  = RVALID && RREADY;
            @(posedge ACLK);
            if (ar_hs) begin ar_done = 1; t_ar = cyc; end
            if (r_hs) begin r_done = 1; data = d0; resp = r0; dlat = cyc - t_ar; end
            cyc++;
        end
        #1;
        ARVALID = 0; RREADY = 0;
        if (!r_done) begin
            n_tests++; n_fail++;
            $display("FAIL read_timeout addr=%h got no R handshake, required one within 300 cycles", a);
        end
    endtask

    task automatic test_reset();
        ARESET = 0;
        repeat (3) @(negedge ACLK);
        n_tests++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got rdy=%b%b%b bv=%b rv=%b bresp=%b rresp=%b rdata=%h required all 0",
                     AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA);
        end
        ARESET = 1;
        #1;
        n_tests++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
            n_fail++; $display("FAIL reset_release_before_edge got %b required 000", {AWREADY, WREADY, ARREADY});
        end
        @(posedge ACLK); #1;
        n_tests++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            n_fail++; $display("FAIL reset_release_first_edge got %b required 111", {AWREADY, WREADY, ARREADY});
        end
        for (int i = 0; i < 16; i++) model[i] = 0;
    endtask

    task automatic test_basic();
        logic [1:0] resp; logic [31:0] d; int lat, v;
        do_write(32'h08, 32'h0000_0013, 4'hF, 0, 0, 0, resp, lat, v);
        model_write(32'h08, 32'h0000_0013, 4'hF);
        n_tests++;
        if (resp !== 2'b00 || lat != 1 || v != 0) begin
            n_fail++; $display("FAIL basic_write got resp=%b lat=%0d viol=%0d required resp=00 lat=1 viol=0", resp, lat, v);
        end
        do_read(32'h08, 0, 0, d, resp, lat, v);
        n_tests++;
        if (d !== model[2] || resp !== 2'b00 || v != 0) begin
            n_fail++; $display("FAIL basic_read got %h/%b viol=%0d required %h/00", d, resp, v, model[2]);
        end
    endtask

    task automatic test_w_first();
        logic [1:0] resp; logic [31:0] d; int lat, v;
        do_write(32'h3C, 32'hA5A5_A5A5, 4'hF, 7, 0, 0, resp, lat, v);
        model_write(32'h3C, 32'hA5A5_A5A5, 4'hF);
        n_tests++;
        if (resp !== 2'b00 || lat != 1 || v != 0) begin
            n_fail++; $display("FAIL w_first_write got resp=%b lat=%0d viol=%0d required resp=00 lat=1 viol=0", resp, lat, v);
        end
        do_read(32'h3C, 0, 0, d, resp, lat, v);
        n_tests++;
        if (d !== model[15] || resp !== 2'b00 || v != 0) begin
            n_fail++; $display("FAIL w_first_read got %h/%b required %h/00", d, resp, model[15]);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp; logic [31:0] d; int lat, v;
        do_write(32'h04, 32'h1122_3344, 4'hF, 0, 2, 1, resp, lat, v);
        model_write(32'h04, 32'h1122_3344, 4'hF);
        do_write(32'h04, 32'hFFFF_FFFF, 4'b0101, 1, 0, 0, resp, lat, v);
        model_write(32'h04, 32'hFFFF_FFFF, 4'b0101);
        do_write(32'h06, 32'hDEAD_BEEF, 4'b0000, 0, 0, 0, resp, lat, v);
        n_tests++;
        if (resp !== 2'b00 || v != 0) begin
            n_fail++; $display("FAIL strobe_zero_resp got %b required 00", resp);
        end
        do_read(32'h05, 0, 0, d, resp, lat, v);
        n_tests++;
        if (d !== model[1] || resp !== 2'b00) begin
            n_fail++; $display("FAIL strobe_read got %h required %h", d, model[1]);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp; logic [31:0] d; int lat, v;
        do_write(32'h40, 32'h5555_AAAA, 4'hF, 0, 0, 0, resp, lat, v);
        n_tests++;
        if (resp !== 2'b10 || v != 0) begin
            n_fail++; $display("FAIL oor_write_resp got %b required 10", resp);
        end
        do_write(32'hFFFF_FFFC, 32'h1234_5678, 4'hF, 3, 1, 0, resp, lat, v);
        n_tests++;
        if (resp !== 2'b10) begin
            n_fail++; $display("FAIL oor_high_write_resp got %b required 10", resp);
        end
        for (int i = 0; i < 16; i++) begin
            do_read(32'(i * 4), 0, 0, d, resp, lat, v);
            n_tests++;
            if (d !== model[i] || resp !== 2'b00) begin
                n_fail++; $display("FAIL oor_regs_unchanged reg%0d got %h/%b required %h/00", i, d, resp, model[i]);
            end
        end
        do_read(32'h40, 0, 0, d, resp, lat, v);
        n_tests++;
        if (d !== 32'h0 || resp !== 2'b10) begin
            n_fail++; $display("FAIL oor_read got %h/%b required 00000000/10", d, resp);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] resp; logic [31:0] d, wd; int lat, v;
        wd = $urandom;
        do_write(32'h20, wd, 4'hF, 0, 0, 25, resp, lat, v);
        model_write(32'h20, wd, 4'hF);
        n_tests++;
        if (resp !== 2'b00 || lat != 25 || v != 0) begin
            n_fail++; $display("FAIL bp_write got resp=%b lat=%0d viol=%0d required 00/25/0", resp, lat, v);
        end
        do_read(32'h20, 0, 25, d, resp, lat, v);
        n_tests++;
        if (d !== model[8] || lat != 25 || v != 0) begin
            n_fail++; $display("FAIL bp_read got %h lat=%0d viol=%0d required %h/25/0", d, lat, v, model[8]);
        end
    endtask

    task automatic test_random_sweep();
        logic [1:0] resp; logic [31:0] a, d; logic [3:0] s; int lat, v, bad = 0;
        for (int i = 0; i < 16; i++) begin
            a = 32'(i * 4) | 32'($urandom_range(0, 3));
            d = $urandom;
            s = 4'($urandom);
            do_write(a, d, s, $urandom_range(1, 30), $urandom_range(1, 30), $urandom_range(1, 30), resp, lat, v);
            model_write(a, d, s);
            if (resp !== 2'b00 || v != 0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL sweep_write_resp got %0d bad writes required 0", bad);
        end
        for (int i = 0; i < 16; i++) begin
            do_read(32'(i * 4), $urandom_range(1, 30), $urandom_range(1, 30), d, resp, lat, v);
            n_tests++;
            if (d !== model[i] || resp !== 2'b00 || v != 0) begin
                n_fail++; $display("FAIL sweep_read reg%0d got %h/%b viol=%0d required %h/00", i, d, resp, v, model[i]);
            end
        end
    endtask

    task automatic test_reset_mid_b();
        logic [1:0] resp; logic [31:0] d; int lat, v;
        @(negedge ACLK);
        AWADDR = 32'h10; WDATA = 32'hCAFE_F00D; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 0;
        @(negedge ACLK);
        AWVALID = 0; WVALID = 0;
        n_tests++;
        if (BVALID !== 1'b1) begin
            n_fail++; $display("FAIL mid_b_bvalid got %b required 1", BVALID);
        end
        #2 ARESET = 0;
        #1;
        n_tests++;
        if (BVALID !== 1'b0 || AWREADY !== 1'b0) begin
            n_fail++; $display("FAIL mid_b_async_drop got bv=%b awr=%b required 0/0", BVALID, AWREADY);
        end
        repeat (2) @(negedge ACLK);
        ARESET = 1;
        for (int i = 0; i < 16; i++) model[i] = 0;
        for (int i = 0; i < 16; i++) begin
            do_read(32'(i * 4), 0, 0, d, resp, lat, v);
            n_tests++;
            if (d !== model[i] || resp !== 2'b00) begin
                n_fail++; $display("FAIL mid_b_regs_cleared reg%0d got %h required %h", i, d, model[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_w_first();
        test_strobe();
        test_out_of_range();
        test_backpressure();
        test_random_sweep();
        test_reset_mid_b();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
